// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the pipelined Booth/Wallace multiplier.
// Optional flush support in the top level is controlled by the MUL_FLUSH_EN macro.
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // Partial-product rows including the negate-correction row.
  function automatic int num_pp(input int xlen);
    return (xlen + 2) / 2 + 1;
  endfunction

  // Rows entering CSA layer 'layer' when starting from n0 rows.
  function automatic int tree_rows(input int n0, input int layer);
    int n;
    n = n0;
    for (int l = 0; l < layer; l++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  function automatic int tree_layers(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      l = l + 1;
    end
    return l;
  endfunction

  function automatic booth_digit_t booth_decode(input logic [2:0] win);
    booth_digit_t d;
    case (win)
      3'b001, 3'b010: d = '{neg: 1'b0, one: 1'b1, two: 1'b0};
      3'b011:         d = '{neg: 1'b0, one: 1'b0, two: 1'b1};
      3'b100:         d = '{neg: 1'b1, one: 1'b0, two: 1'b1};
      3'b101, 3'b110: d = '{neg: 1'b1, one: 1'b1, two: 1'b0};
      default:        d = '{neg: 1'b0, one: 1'b0, two: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: digit x extended multiplicand, sign-extended,
// shifted into place; a negative digit is emitted inverted with its +1 returned as neg.
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SHIFT = 0
) (
  input  logic [2:0]        win,
  input  logic [XLEN+1:0]   a_ext,
  output logic [2*XLEN-1:0] pp,
  output logic              neg
);

  localparam int PW = 2 * XLEN;
  localparam int EW = XLEN + 2;

  booth_digit_t  dig_s;
  logic [PW-1:0] a_sx_s;
  logic [PW-1:0] mag_s;
  logic [PW-1:0] sel_s;

  // Select 0/1x/2x, invert for negative digits, then move to the row weight.
  always_comb begin
    dig_s  = booth_decode(win);
    a_sx_s = {{(PW - EW){a_ext[EW-1]}}, a_ext};
    if (dig_s.two) begin
      mag_s = {a_sx_s[PW-2:0], 1'b0};
    end else if (dig_s.one) begin
      mag_s = a_sx_s;
    end else begin
      mag_s = '0;
    end
    if (dig_s.neg) begin
      sel_s = ~mag_s;
    end else begin
      sel_s = mag_s;
    end
    pp  = sel_s << SHIFT;
    neg = dig_s.neg;
  end

endmodule

// File: rtl/wallace_mul_pipe.sv
// 3-stage RISC-V M multiplier: Booth PP generation, CSA tree, final add/select.
// Define MUL_FLUSH_EN to add the flush input that discards all in-flight operations.
module wallace_mul_pipe
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
`ifdef MUL_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  localparam int PW   = 2 * XLEN;
  localparam int EW   = XLEN + 2;
  localparam int NPP  = EW / 2;
  localparam int NROW = num_pp(XLEN);
  localparam int NL   = tree_layers(NROW);

  if (((XLEN % 2) != 0) || (XLEN < 8)) begin : g_bad_xlen
    $error("wallace_mul_pipe: XLEN must be even and >= 8");
  end

  logic adv_s;
  logic flush_s;

`ifdef MUL_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s && !flush_s;

  // ---------------- stage 1: operand extension and Booth rows
  logic          a_sgn_s;
  logic          b_sgn_s;
  logic [EW-1:0] a_ext_s;
  logic [EW-1:0] b_ext_s;
  logic [EW:0]   b_pad_s;
  logic [PW-1:0] pp_s [NPP];
  logic [NPP-1:0] neg_s;
  logic [PW-1:0] corr_s;

  // Extend operands by two bits according to the signedness of the variant.
  always_comb begin
    a_sgn_s = (in_op == OP_MULH) || (in_op == OP_MULHSU);
    b_sgn_s = (in_op == OP_MULH);
    a_ext_s = {{2{a_sgn_s & in_a[XLEN-1]}}, in_a};
    b_ext_s = {{2{b_sgn_s & in_b[XLEN-1]}}, in_b};
    b_pad_s = {b_ext_s, 1'b0};
  end

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    booth_pp_gen #(
      .XLEN  (XLEN),
      .SHIFT (2 * i)
    ) u_pp (
      .win   (b_pad_s[2*i+2:2*i]),
      .a_ext (a_ext_s),
      .pp    (pp_s[i]),
      .neg   (neg_s[i])
    );
  end

  // Every row's +1 lands on a distinct even bit, so one correction row suffices.
  always_comb begin
    corr_s = '0;
    for (int i = 0; i < NPP; i++) begin
      corr_s[2*i] = neg_s[i];
    end
  end

  logic             s1_valid_q, s1_valid_d;
  mul_op_e          s1_op_q,    s1_op_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
  logic [PW-1:0]    s1_row_q [NROW];
  logic [PW-1:0]    s1_row_d [NROW];

  // ---------------- stage 2: carry-save reduction to two rows
  logic [PW-1:0] tree_s [NL+1][NROW];

  for (genvar r = 0; r < NROW; r++) begin : g_l0
    assign tree_s[0][r] = s1_row_q[r];
  end

  for (genvar l = 0; l < NL; l++) begin : g_layer
    localparam int NIN  = tree_rows(NROW, l);
    localparam int NGRP = NIN / 3;
    localparam int NOUT = 2 * NGRP + (NIN % 3);
    for (genvar g = 0; g < NGRP; g++) begin : g_csa
      assign tree_s[l+1][2*g]   = tree_s[l][3*g] ^ tree_s[l][3*g+1] ^ tree_s[l][3*g+2];
      assign tree_s[l+1][2*g+1] = ((tree_s[l][3*g]   & tree_s[l][3*g+1]) |
                                   (tree_s[l][3*g]   & tree_s[l][3*g+2]) |
                                   (tree_s[l][3*g+1] & tree_s[l][3*g+2])) << 1;
    end
    for (genvar r = 0; r < (NIN % 3); r++) begin : g_pass
      assign tree_s[l+1][2*NGRP+r] = tree_s[l][3*NGRP+r];
    end
    for (genvar r = NOUT; r < NROW; r++) begin : g_zero
      assign tree_s[l+1][r] = '0;
    end
  end

  logic             s2_valid_q, s2_valid_d;
  mul_op_e          s2_op_q,    s2_op_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
  logic [PW-1:0]    s2_sum_q,   s2_sum_d;
  logic [PW-1:0]    s2_carry_q, s2_carry_d;

  // ---------------- stage 3: carry-propagate add and half select
  logic [PW-1:0]   prod_s;
  logic [XLEN-1:0] res_s;

  // Low half for MUL, high half for every MULH variant.
  always_comb begin
    prod_s = s2_sum_q + s2_carry_q;
    case (s2_op_q)
      OP_MUL:  res_s = prod_s[XLEN-1:0];
      default: res_s = prod_s[PW-1:XLEN];
    endcase
  end

  logic             out_valid_q,  out_valid_d;
  logic [XLEN-1:0]  out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q,    out_tag_d;

  // Lock-step advance; flush clears only the valid bits, data holds.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_tag_d     = s1_tag_q;
    s1_row_d     = s1_row_q;
    s2_valid_d   = s2_valid_q;
    s2_op_d      = s2_op_q;
    s2_tag_d     = s2_tag_q;
    s2_sum_d     = s2_sum_q;
    s2_carry_d   = s2_carry_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    if (flush_s) begin
      s1_valid_d  = 1'b0;
      s2_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else if (adv_s) begin
      s1_valid_d = in_valid;
      s1_op_d    = mul_op_e'(in_op);
      s1_tag_d   = in_tag;
      for (int i = 0; i < NPP; i++) begin
        s1_row_d[i] = pp_s[i];
      end
      s1_row_d[NPP] = corr_s;
      s2_valid_d   = s1_valid_q;
      s2_op_d      = s1_op_q;
      s2_tag_d     = s1_tag_q;
      s2_sum_d     = tree_s[NL][0];
      s2_carry_d   = tree_s[NL][1];
      out_valid_d  = s2_valid_q;
      out_result_d = res_s;
      out_tag_d    = s2_tag_q;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_MUL;
      s1_tag_q     <= '0;
      s1_row_q     <= '{default: '0};
      s2_valid_q   <= 1'b0;
      s2_op_q      <= OP_MUL;
      s2_tag_q     <= '0;
      s2_sum_q     <= '0;
      s2_carry_q   <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_tag_q     <= s1_tag_d;
      s1_row_q     <= s1_row_d;
      s2_valid_q   <= s2_valid_d;
      s2_op_q      <= s2_op_d;
      s2_tag_q     <= s2_tag_d;
      s2_sum_q     <= s2_sum_d;
      s2_carry_q   <= s2_carry_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Directed bench for wallace_mul_pipe (XLEN=32) plus a scoreboarded random stream.
module tb_wallace_mul_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [XLEN-1:0]  in_a = '0;
  logic [XLEN-1:0]  in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
`ifdef MUL_FLUSH_EN
  logic             flush = 1'b0;
`endif

  wallace_mul_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
`ifdef MUL_FLUSH_EN
    ,
    .flush      (flush)
`endif
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  // Request driven after edge N is captured at N+1 and appears after edge N+3.
  task automatic run_single(input string nm, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    @(posedge clk); #1;
    out_ready = 1'b1;
    set_req(op, a, b, tag);
    check_eq({nm, "_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({nm, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    check_eq({nm, "_lat2"}, out_valid, 0);
    @(posedge clk); #1;
    check_eq({nm, "_valid"}, out_valid, 1);
    check_eq({nm, "_result"}, out_result, exp);
    check_eq({nm, "_tag"}, out_tag, tag);
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0] ax;
    logic signed [65:0] bx;
    logic signed [65:0] p;
    ax = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'd0, a};
    bx = (op == 2'b01) ? {{34{b[31]}}, b} : {34'd0, b};
    p  = ax * bx;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [6];
    corners = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                32'h8000_0000, 32'h7FFF_FFFF, 32'hAAAA_5555};
    if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
    else return $urandom;
  endfunction

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] res;
  } exp_t;

  exp_t sb [$];

  initial begin
    logic [31:0] exp4 [6];
    exp4 = '{32'h300, 32'h600, 32'h900, 32'hC00, 32'hF00, 32'h1200};

    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_result", out_result, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_single("mul_ones",      2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0001);
    run_single("mulh_min",      2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000);
    run_single("mulhu_min",     2'b11, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000);
    run_single("mulhsu_min",    2'b10, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'hC000_0000);
    run_single("mulhsu_ones",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF);
    run_single("mulhu_ones",    2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE);
    run_single("mulh_ones",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'h0000_0000);
    run_single("mulh_max",      2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd10, 32'h3FFF_FFFF);
    run_single("mul_small",     2'b00, 32'h0000_0007, 32'h0000_0006, 5'd11, 32'h0000_002A);
    run_single("mul_shift",     2'b00, 32'h1234_5678, 32'h0000_0010, 5'd12, 32'h2345_6780);
    run_single("mul_neg",       2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 5'd13, 32'hFFFF_FFFA);
    run_single("mulh_neg",      2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'd14, 32'hFFFF_FFFF);

    // Back-to-back stream with a 3-cycle output stall.
    @(posedge clk); #1;
    out_ready = 1'b1;
    fork
      begin : drv
        for (int i = 0; i < 6; i++) begin
          set_req(2'b00, (i + 1) * 256, 32'd3, i + 1);
          for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready) break;
          end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin : stl
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin : mon
        int k;
        int stalls;
        k = 0;
        stalls = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
          @(negedge clk);
          if (out_valid && !out_ready) begin
            stalls++;
            check_eq("stall_in_ready", in_ready, 0);
            check_eq("stall_tag", out_tag, k + 1);
            check_eq("stall_result", out_result, exp4[k]);
          end else begin
            check_eq("flow_in_ready", in_ready, 1);
            if (out_valid) begin
              check_eq("b2b_tag", out_tag, k + 1);
              check_eq("b2b_result", out_result, exp4[k]);
              k++;
            end
          end
        end
        check_eq("b2b_count", k, 6);
        check_eq("b2b_stalls", stalls, 3);
      end
    join

    // Reset with three operations in flight.
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 20 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("inflight_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_out_result", out_result, 0);
    check_eq("arst_out_tag", out_tag, 0);
    check_eq("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_single("post_rst", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 5'd25, 32'h0000_0001);

`ifdef MUL_FLUSH_EN
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      set_req(2'b00, 32'd5, 32'd5, 26 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    flush = 1'b1;
    #1 check_eq("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check_eq("flush_drain1", out_valid, 0);
    @(posedge clk); #1;
    check_eq("flush_drain2", out_valid, 0);
`endif

    // Random stream against the reference model.
    begin
      logic       accepted;
      logic [4:0] next_tag;
      exp_t       e;
      next_tag = 5'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < 1520; c++) begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          check_eq("rnd_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("rnd_tag", out_tag, e.tag);
            check_eq("rnd_result", out_result, e.res);
          end
        end
        accepted = in_valid && in_ready;
        if (accepted) sb.push_back({in_tag, ref_mul(in_op, in_a, in_b)});
        @(posedge clk); #1;
        if (c >= 1500) begin
          in_valid  = 1'b0;
          out_ready = 1'b1;
        end else begin
          if (accepted || !in_valid) begin
            in_valid = ($urandom_range(3) != 0);
            in_op    = 2'($urandom_range(3));
            in_a     = pick_operand();
            in_b     = pick_operand();
            in_tag   = next_tag;
            next_tag = next_tag + 5'd1;
          end
          out_ready = ($urandom_range(3) != 0);
        end
      end
      check_eq("rnd_drained", sb.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
